bus_tx_framer: RTL

- Upstream stage of the shared-bus data_bus endpoint; one instance per bus client (SHA, AES, control).
- Buffers a byte payload from the client core, prepends a header byte, and streams header+payload into data_bus over send_valid/send_ready.
- Waits for the bus ack. Re-sends the whole frame on ack timeout, up to a retry limit, then reports an error.

---
 rtl/bus_tx_framer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bus_tx_framer.sv
//------------------------------------------------------------------------------
// Module      : bus_tx_framer
// Description : Buffers a client payload, prepends a header byte and streams the
//               frame to data_bus; re-sends on ack timeout up to a retry limit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_tx_framer #(
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] src_id,
    input  logic [1:0] dest_id,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       send_valid,
    output logic [7:0] send_data,
    input  logic       send_ready,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int              c_aw        = $clog2(DEPTH);
    localparam int              c_lw        = c_aw + 1;
    localparam logic [c_lw-1:0] c_depth     = c_lw'(DEPTH);
    localparam logic [7:0]      c_tmo_last  = 8'(TIMEOUT - 1);
    localparam logic [2:0]      c_max_retry = 3'(MAX_RETRY);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_fill = 3'd1;
    localparam logic [2:0] c_st_hdr  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_wait = 3'd4;

    logic [2:0]      r_state, w_state_nx;
    logic [c_lw-1:0] r_wr, w_wr_nx;
    logic [c_aw-1:0] r_rd, w_rd_nx;
    logic [1:0]      r_dest, w_dest_nx;
    logic [7:0]      r_timer, w_timer_nx;
    logic [2:0]      r_retry, w_retry_nx;
    logic [7:0]      r_buf [DEPTH];

    logic            r_in_ready, w_in_ready_nx;
    logic            r_send_valid, w_send_valid_nx;
    logic [7:0]      r_send_data, w_send_data_nx;
    logic            r_busy, w_busy_nx;
    logic            r_done, w_done_nx;
    logic            r_err, w_err_nx;

    logic            w_wr_en;
    logic [c_aw-1:0] w_wr_idx;
    logic            w_accept;
    logic            w_xfer;
    logic            w_last_rd;

    assign w_accept  = in_valid & r_in_ready;
    assign w_xfer    = send_ready & r_send_valid;
    assign w_last_rd = ({1'b0, r_rd} == (r_wr - c_lw'(1)));
    assign w_wr_idx  = (r_state == c_st_idle) ? '0 : r_wr[c_aw-1:0];

    assign in_ready   = r_in_ready;
    assign send_valid = r_send_valid;
    assign send_data  = r_send_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

    always_comb begin
        w_state_nx = r_state;
        w_wr_nx    = r_wr;
        w_rd_nx    = r_rd;
        w_dest_nx  = r_dest;
        w_timer_nx = r_timer;
        w_retry_nx = r_retry;
        w_wr_en    = 1'b0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_wr_en    = 1'b1;
                    w_dest_nx  = dest_id;
                    w_wr_nx    = c_lw'(1);
                    w_retry_nx = '0;
                    w_state_nx = in_last ? c_st_hdr : c_st_fill;
                end
            end
            c_st_fill: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    w_wr_nx = r_wr + c_lw'(1);
                    // A full buffer closes the frame even without in_last.
                    if (in_last || (w_wr_nx == c_depth)) begin
                        w_state_nx = c_st_hdr;
                    end
                end
            end
            c_st_hdr: begin
                if (w_xfer) begin
                    w_rd_nx    = '0;
                    w_state_nx = c_st_data;
                end
            end
            c_st_data: begin
                if (w_xfer) begin
                    if (w_last_rd) begin
                        w_timer_nx = '0;
                        w_state_nx = c_st_wait;
                    end else begin
                        w_rd_nx = r_rd + c_aw'(1);
                    end
                end
            end
            c_st_wait: begin
                if (ack) begin
                    w_done_nx  = 1'b1;
                    w_retry_nx = '0;
                    w_state_nx = c_st_idle;
                end else if (r_timer == c_tmo_last) begin
                    if (r_retry < c_max_retry) begin
                        w_retry_nx = r_retry + 3'd1;
                        w_state_nx = c_st_hdr;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_retry_nx = '0;
                        w_state_nx = c_st_idle;
                    end
                end else begin
                    w_timer_nx = r_timer + 8'd1;
                end
            end
            default: w_state_nx = c_st_idle;
        endcase

        // Outputs are derived from the next state so they can be registered.
        w_in_ready_nx   = (w_state_nx == c_st_idle) || (w_state_nx == c_st_fill);
        w_send_valid_nx = (w_state_nx == c_st_hdr) || (w_state_nx == c_st_data);
        w_busy_nx       = (w_state_nx != c_st_idle);
        w_send_data_nx  = r_send_data;
        if (w_state_nx == c_st_hdr) begin
            w_send_data_nx = {w_dest_nx, src_id, 4'(w_wr_nx - c_lw'(1))};
        end else if (w_state_nx == c_st_data) begin
            w_send_data_nx = r_buf[w_rd_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_wr         <= '0;
            r_rd         <= '0;
            r_dest       <= '0;
            r_timer      <= '0;
            r_retry      <= '0;
            r_in_ready   <= 1'b0;
            r_send_valid <= 1'b0;
            r_send_data  <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_wr         <= w_wr_nx;
            r_rd         <= w_rd_nx;
            r_dest       <= w_dest_nx;
            r_timer      <= w_timer_nx;
            r_retry      <= w_retry_nx;
            r_in_ready   <= w_in_ready_nx;
            r_send_valid <= w_send_valid_nx;
            r_send_data  <= w_send_data_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= in_data;
        end
    end

endmodule

`default_nettype wire
